fdiv16_iter: RTL and testbench
==============================

Name: fdiv16_iter

Overview:
- Iterative IEEE-754 half-precision divider, result = a / b. It is the inverse-operation companion to the combinational fp16 multiplier in the FP datapath.
- Multi-cycle, with a start/done handshake. Intended to be driven by the multi-cycle control unit as a long-latency execute operation.
- Number conventions match the multiplier exactly:
  - hidden 1 is always assumed (no denormals);
  - mantissa result is truncated (no rounding);
  - exponent arithmetic is 5-bit modulo, with no overflow/underflow detection;
  - an operand is zero when bits[14:0] == 0.

Parameters:
- BIAS, 15, exponent bias added after the exponent subtraction.
- QBITS, 12, number of quotient bits generated: 1 integer bit, 1 hidden bit, 10 fraction bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- a  in  16  dividend (fp16); sampled on the accepting edge
- b  in  16  divisor (fp16); sampled on the accepting edge
- busy  out  1  high while in DIVIDE or NORM
- done  out  1  one-cycle pulse; result valid from this cycle on
- result  out  16  quotient; held until the next accepted start
- div_by_zero  out  1  set with done when b is zero; held with result

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Asserting rst_n=0 at any time, including mid-division, forces state IDLE.
  - Outputs on reset: busy=0, done=0, result=16'h0000, div_by_zero=0. Internal registers are cleared.
- States: IDLE, DIVIDE, NORM, DONE.
- Accept: start=1 at a clock edge while in IDLE or DONE.
  - Latch sign = a[15]^b[15].
  - Latch zero flags za, zb.
  - Latch exp_pre = a[14:10] - b[14:10] + BIAS (5-bit, modulo).
  - Latch rem = {1'b0, 1, a[9:0]} (12 bits) and div = {1, b[9:0]} (11 bits).
  - Clear the counter, then go to DIVIDE.
- start in DIVIDE or NORM is ignored; operands are not resampled.
- DIVIDE: one quotient bit per cycle, MSB first, restoring algorithm.
  - If rem >= div: qbit=1 and rem = (rem - div) << 1.
  - Else: qbit=0 and rem = rem << 1.
  - The quotient shift register takes qbit in at the LSB.
  - After 12 cycles (count 0..11), go to NORM.
- NORM: produces the result.
  - If q[11]=1: mant = q[10:1], exp = exp_pre.
  - Else: mant = q[9:0], exp = exp_pre - 1 (5-bit modulo).
  - Special-case priority, top wins:
    - za & zb: result = 16'h7E00, div_by_zero=1.
    - zb: result = {sign, 5'h1F, 10'h0}, div_by_zero=1.
    - za: result = {sign, 15'h0}, div_by_zero=0.
    - otherwise: result = {sign, exp, mant}, div_by_zero=0.
  - Go to DONE with done=1.
- DONE: done drops to 0 after one cycle. result and div_by_zero are held.
  - The block stays in DONE until the next accepted start; start in DONE is accepted exactly as in IDLE.
- Latency: fixed for all operands, including special cases.
  - Accepting edge E0, DIVIDE on edges E1..E12, NORM on E13.
  - done=1 and result valid in the cycle after E13, i.e. 13 cycles after acceptance.
- Throughput: a start asserted in the done cycle is accepted. Back-to-back operations therefore run every 14 cycles.
- Widths:
  - rem is 12 bits and never exceeds 2*div - 1 < 4096, so there is no overflow.
  - The quotient register is 12 bits.
  - Exponent arithmetic wraps modulo 32 and never saturates.

Test Plan:
- Reset mid-op: start with a=0x4200, b=0x3E00, then pull rst_n low at the 5th DIVIDE cycle.
  - -> busy=0, done=0, result=0x0000 immediately.
  - After release, no done pulse appears without a new start.
- Normal case: a=0x4200 (3.0), b=0x3E00 (1.5), start.
  - -> done exactly 13 cycles later, result=0x4000, div_by_zero=0.
  - busy is high for cycles 1..13.
- Normalize-down path: a=0x3C00 (1.0), b=0x3E00 (1.5).
  - -> result=0x3955, truncated 0.6665.
  - Sign path: a=0xC600 (-6.0), b=0x4000 -> result=0xC200.
- Special cases, all at 13-cycle latency:
  - a=0x4500, b=0x8000 -> result=0xFC00, div_by_zero=1.
  - a=0x0000, b=0x4700 -> result=0x0000, div_by_zero=0.
  - a=0x8000, b=0x0000 -> result=0x7E00, div_by_zero=1.
- Handshake:
  - start re-pulsed with new operands during DIVIDE -> ignored; first result unchanged.
  - start held high across the done cycle -> second operation accepted there; its done comes 13 cycles later.
  - Between operations, result is stable while in DONE.

Source files
------------

// File: rtl/fdiv16_if.sv
// fdiv16_if: start/done handshake and operand/result bus for the fp16 divider
interface fdiv16_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        div_by_zero;
  modport master (output start, a, b, input busy, done, result, div_by_zero);
  modport slave (input start, a, b, output busy, done, result, div_by_zero);
endinterface

// File: rtl/fdiv16_iter.sv
// fdiv16_iter: iterative fp16 divider (restoring, 12 quotient bits, truncated, no denormals); ports clk, rst_n, io (start/a/b in, busy/done/result/div_by_zero out)
module fdiv16_iter #(
  parameter logic [4:0] BIAS  = 5'd15,
  parameter int         QBITS = 12
) (
  input logic clk,
  input logic rst_n,
  fdiv16_if.slave io
);
  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;
  state_t      state_q;
  logic        sign_q, za_q, zb_q, busy_q, done_q, dbz_q;
  logic [4:0]  exp_q;
  logic [11:0] rem_q, quo_q;
  logic [10:0] div_q;
  logic [3:0]  cnt_q;
  logic [15:0] result_q;
  logic        ge;
  logic [11:0] rem_d, quo_d;
  logic [9:0]  mant;
  logic [4:0]  exp_n, exp_d;
  logic [15:0] result_d;
  always_comb begin
    ge       = rem_q >= {1'b0, div_q};
    rem_d    = ge ? (rem_q - {1'b0, div_q}) << 1 : rem_q << 1;
    quo_d    = {quo_q[10:0], ge};
    mant     = quo_q[11] ? quo_q[10:1] : quo_q[9:0];
    exp_n    = quo_q[11] ? exp_q : exp_q - 5'd1;
    exp_d    = io.a[14:10] - io.b[14:10] + BIAS;
    result_d = (za_q && zb_q) ? 16'h7E00 :
               zb_q ? {sign_q, 5'h1F, 10'h0} :
               za_q ? {sign_q, 15'h0} : {sign_q, exp_n, mant};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      za_q     <= 1'b0;
      zb_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      exp_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (io.start) begin
            sign_q  <= io.a[15] ^ io.b[15];
            za_q    <= io.a[14:0] == 15'h0;
            zb_q    <= io.b[14:0] == 15'h0;
            exp_q   <= exp_d;
            rem_q   <= {2'b01, io.a[9:0]};
            div_q   <= {1'b1, io.b[9:0]};
            quo_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= DIVIDE;
          end
        end
        DIVIDE: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'(QBITS - 1)) state_q <= NORM;
        end
        NORM: begin
          result_q <= result_d;
          dbz_q    <= zb_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= DONE;
        end
      endcase
    end
  end
  assign io.busy        = busy_q;
  assign io.done        = done_q;
  assign io.result      = result_q;
  assign io.div_by_zero = dbz_q;
endmodule

// File: tb/tb_fdiv16_iter.sv
// tb_fdiv16_iter: table-driven and hand-sequenced checks of fdiv16_iter
module tb_fdiv16_iter;
  logic clk = 1'b0;
  logic rst_n;
  fdiv16_if io ();
  fdiv16_iter dut (.clk(clk), .rst_n(rst_n), .io(io));
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        dbz;
  } vec_t;
  vec_t vecs [9];
  int tests = 0;
  int errors = 0;
  int lat;
  logic busy_ok;
  logic seen;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    io.start = 1'b1;
    io.a = a;
    io.b = b;
    @(posedge clk);
    @(negedge clk);
    io.start = 1'b0;
  endtask
  task automatic wait_done(input int repulse, output int n, output logic ok);
    n = 0;
    ok = 1'b1;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (io.done ? io.busy : !io.busy) ok = 1'b0;
      if (io.done) break;
      io.start = (n == repulse);
      if (n == repulse) begin
        io.a = 16'h3C00;
        io.b = 16'h3E00;
      end
    end
    io.start = 1'b0;
  endtask
  initial begin
    vecs[0] = '{16'h4200, 16'h3E00, 16'h4000, 1'b0};
    vecs[1] = '{16'h3C00, 16'h3E00, 16'h3955, 1'b0};
    vecs[2] = '{16'hC600, 16'h4000, 16'hC200, 1'b0};
    vecs[3] = '{16'h4500, 16'h8000, 16'hFC00, 1'b1};
    vecs[4] = '{16'h0000, 16'h4700, 16'h0000, 1'b0};
    vecs[5] = '{16'h8000, 16'h0000, 16'h7E00, 1'b1};
    vecs[6] = '{16'h3C00, 16'h3C00, 16'h3C00, 1'b0};
    vecs[7] = '{16'h4000, 16'h4200, 16'h3955, 1'b0};
    vecs[8] = '{16'h0400, 16'h7800, 16'h4800, 1'b0};
    io.start = 1'b0;
    io.a = '0;
    io.b = '0;
    rst_n = 1'b0;
    #1;
    chk("reset_busy", 32'(io.busy), 0);
    chk("reset_done", 32'(io.done), 0);
    chk("reset_result", 32'(io.result), 0);
    chk("reset_dbz", 32'(io.div_by_zero), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].a, vecs[i].b);
      wait_done(0, lat, busy_ok);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 13);
      chk($sformatf("vec%0d_busy", i), 32'(busy_ok), 1);
      chk($sformatf("vec%0d_result", i), 32'(io.result), 32'(vecs[i].res));
      chk($sformatf("vec%0d_dbz", i), 32'(io.div_by_zero), 32'(vecs[i].dbz));
      @(negedge clk);
    end
    issue(16'h4200, 16'h3E00);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(io.busy), 0);
    chk("midreset_done", 32'(io.done), 0);
    chk("midreset_result", 32'(io.result), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (io.done || io.busy) seen = 1'b1;
    end
    chk("midreset_no_done", 32'(seen), 0);
    issue(16'h4200, 16'h3E00);
    wait_done(3, lat, busy_ok);
    chk("repulse_latency", 32'(lat), 13);
    chk("repulse_result", 32'(io.result), 32'h4000);
    issue(16'h3C00, 16'h3E00);
    wait_done(0, lat, busy_ok);
    chk("b2b_latency", 32'(lat), 13);
    chk("b2b_busy", 32'(busy_ok), 1);
    chk("b2b_result", 32'(io.result), 32'h3955);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (io.done || io.result !== 16'h3955 || io.busy) seen = 1'b1;
    end
    chk("done_hold_stable", 32'(seen), 0);
    chk("done_hold_result", 32'(io.result), 32'h3955);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
